// File: rtl/sd_cmd_sequencer_if.sv
// Command/response and SPI byte-transfer signals between the SD controller,
// the command sequencer and the byte-wide SPI shift engine.
interface sd_cmd_sequencer_if;
   logic        start;
   logic        abort;
   logic [5:0]  cmd_idx;
   logic [0:31] cmd_arg;
   logic        busy;
   logic        done;
   logic        timeout;
   logic [0:7]  r1;
   logic [0:7]  spi_tx;
   logic        spi_req;
   logic        spi_ack;
   logic [0:7]  spi_rx;

   // Bit 0 of every byte/argument vector is the MSB, matching the SD types.
   modport master (
      input  start, abort, cmd_idx, cmd_arg, spi_ack, spi_rx,
      output busy, done, timeout, r1, spi_tx, spi_req
   );

   modport slave (
      output start, abort, cmd_idx, cmd_arg, spi_ack, spi_rx,
      input  busy, done, timeout, r1, spi_tx, spi_req
   );
endinterface

// File: rtl/sd_cmd_sequencer.sv
// Frames one SPI-mode SD command (filler, start byte, argument, CRC7), then
// polls for the R1 response and reports it back to the SD controller.
module sd_cmd_sequencer #(
   parameter int PRE_FF  = 1,
   parameter int NCR_MAX = 8
) (
   input logic                 clk,
   input logic                 reset_n,
   sd_cmd_sequencer_if.master  bus
);

   typedef enum logic [2:0] {IDLE, FILL, SEND, POLL, FIN} seqState_t;

   seqState_t   state, stateNext;
   logic        spiReq, spiReqNext;
   logic [0:7]  spiTx, spiTxNext;
   logic [6:0]  crc, crcNext;
   logic [2:0]  byteCnt, byteCntNext;
   logic [7:0]  pollCnt, pollCntNext;
   logic [5:0]  idxLatch, idxLatchNext;
   logic [0:31] argLatch, argLatchNext;
   logic        busyReg, busyNext;
   logic        doneReg, doneNext;
   logic        timeoutReg, timeoutNext;
   logic [0:7]  r1Reg, r1Next;
   logic [0:7]  frameByte;

   // CRC7 (x^7 + x^3 + 1), fed MSB first.
   function automatic logic [6:0] crc7(input logic [0:7] data, input logic [6:0] crcIn);
      logic [6:0] c;
      logic       fb;
      c = crcIn;
      for (int i = 0; i < 8; i++) begin
         fb = c[6] ^ data[i];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ 7'h09;
      end
      return c;
   endfunction

   // The last frame byte uses the CRC accumulated over the first five bytes.
   always_comb begin
      frameByte = 8'hFF;
      case (byteCnt)
         3'd0:    frameByte = {2'b01, idxLatch};
         3'd1:    frameByte = argLatch[0:7];
         3'd2:    frameByte = argLatch[8:15];
         3'd3:    frameByte = argLatch[16:23];
         3'd4:    frameByte = argLatch[24:31];
         3'd5:    frameByte = {crc, 1'b1};
         default: frameByte = 8'hFF;
      endcase
   end

   // A byte is loaded in a cycle where no request is pending, so spi_tx never
   // moves under an active request and one idle cycle always follows the ack.
   always_comb begin
      stateNext    = state;
      spiReqNext   = spiReq;
      spiTxNext    = spiTx;
      crcNext      = crc;
      byteCntNext  = byteCnt;
      pollCntNext  = pollCnt;
      idxLatchNext = idxLatch;
      argLatchNext = argLatch;
      busyNext     = busyReg;
      doneNext     = 1'b0;
      timeoutNext  = timeoutReg;
      r1Next       = r1Reg;

      if (bus.abort && (state == FILL || state == SEND || state == POLL)) begin
         spiReqNext  = 1'b0;
         doneNext    = 1'b1;
         timeoutNext = 1'b1;
         r1Next      = 8'hFF;
         busyNext    = 1'b0;
         stateNext   = FIN;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start && !bus.abort) begin
                  idxLatchNext = bus.cmd_idx;
                  argLatchNext = bus.cmd_arg;
                  busyNext     = 1'b1;
                  timeoutNext  = 1'b0;
                  r1Next       = 8'hFF;
                  crcNext      = 7'd0;
                  byteCntNext  = 3'd0;
                  pollCntNext  = 8'd0;
                  stateNext    = (PRE_FF > 0) ? FILL : SEND;
               end
            end
            FILL: begin
               if (!spiReq) begin
                  spiReqNext = 1'b1;
                  spiTxNext  = 8'hFF;
               end else if (bus.spi_ack) begin
                  spiReqNext = 1'b0;
                  if (byteCnt == 3'(PRE_FF - 1)) begin
                     byteCntNext = 3'd0;
                     stateNext   = SEND;
                  end else begin
                     byteCntNext = byteCnt + 3'd1;
                  end
               end
            end
            SEND: begin
               if (!spiReq) begin
                  spiReqNext = 1'b1;
                  spiTxNext  = frameByte;
                  if (byteCnt != 3'd5) crcNext = crc7(frameByte, crc);
               end else if (bus.spi_ack) begin
                  spiReqNext = 1'b0;
                  if (byteCnt == 3'd5) begin
                     pollCntNext = 8'd0;
                     stateNext   = POLL;
                  end else begin
                     byteCntNext = byteCnt + 3'd1;
                  end
               end
            end
            POLL: begin
               if (!spiReq) begin
                  spiReqNext = 1'b1;
                  spiTxNext  = 8'hFF;
               end else if (bus.spi_ack) begin
                  spiReqNext  = 1'b0;
                  pollCntNext = pollCnt + 8'd1;
                  if (!bus.spi_rx[0]) begin
                     r1Next      = bus.spi_rx;
                     timeoutNext = 1'b0;
                     doneNext    = 1'b1;
                     busyNext    = 1'b0;
                     stateNext   = FIN;
                  end else if (pollCnt == 8'(NCR_MAX - 1)) begin
                     r1Next      = 8'hFF;
                     timeoutNext = 1'b1;
                     doneNext    = 1'b1;
                     busyNext    = 1'b0;
                     stateNext   = FIN;
                  end
               end
            end
            FIN: begin
               stateNext = IDLE;
            end
            default: begin
               stateNext = IDLE;
            end
         endcase
      end
   end

   // State and datapath register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         spiReq     <= 1'b0;
         spiTx      <= 8'hFF;
         crc        <= 7'd0;
         byteCnt    <= 3'd0;
         pollCnt    <= 8'd0;
         idxLatch   <= 6'd0;
         argLatch   <= 32'd0;
         busyReg    <= 1'b0;
         doneReg    <= 1'b0;
         timeoutReg <= 1'b0;
         r1Reg      <= 8'hFF;
      end else begin
         state      <= stateNext;
         spiReq     <= spiReqNext;
         spiTx      <= spiTxNext;
         crc        <= crcNext;
         byteCnt    <= byteCntNext;
         pollCnt    <= pollCntNext;
         idxLatch   <= idxLatchNext;
         argLatch   <= argLatchNext;
         busyReg    <= busyNext;
         doneReg    <= doneNext;
         timeoutReg <= timeoutNext;
         r1Reg      <= r1Next;
      end
   end

   assign bus.spi_req = spiReq;
   assign bus.spi_tx  = spiTx;
   assign bus.busy    = busyReg;
   assign bus.done    = doneReg;
   assign bus.timeout = timeoutReg;
   assign bus.r1      = r1Reg;

endmodule
